// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester.
package apb_pkg;
  localparam int APB_ADDR_W_DEF  = 32;
  localparam int APB_DATA_W_DEF  = 32;
  localparam int APB_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;

  typedef logic [2:0] apb_prot_t;

  localparam int PPROT_PRIV_BIT   = 0;
  localparam int PPROT_NONSEC_BIT = 1;
  localparam int PPROT_INSTR_BIT  = 2;

  // Wait counter must hold the limit itself; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction
endpackage

// File: rtl/apb_timeout_counter.sv
// Saturating wait-state counter; expired marks the wait cycle that reaches the limit.
module apb_timeout_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   nxt;

  assign nxt = {1'b0, cnt} + 1'b1;
  // Look-ahead compare so the abort lands in the same cycle the count reaches the limit.
  assign expired = enable && (limit != '0) && (nxt >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1) && ((limit == '0) || (cnt < limit))) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 requester: one outstanding valid/ready request mapped onto SETUP/ACCESS, buffered response.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int APB_PADDR_WIDTH = APB_ADDR_W_DEF,
  parameter int APB_PDATA_WIDTH = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES  = APB_TIMEOUT_DEF
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [APB_PADDR_WIDTH-1:0]   req_addr,
  input  logic [APB_PDATA_WIDTH-1:0]   req_wdata,
  input  logic [APB_PDATA_WIDTH/8-1:0] req_strb,
  input  apb_prot_t                    req_prot,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [APB_PDATA_WIDTH-1:0]   rsp_rdata,
  output logic                         rsp_err,
  output logic                         rsp_timeout,
  output logic [APB_PADDR_WIDTH-1:0]   PADDR,
  output apb_prot_t                    PPROT,
  output logic                         PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [APB_PDATA_WIDTH-1:0]   PWDATA,
  output logic [APB_PDATA_WIDTH/8-1:0] PSTRB,
  input  logic                         PREADY,
  input  logic [APB_PDATA_WIDTH-1:0]   PRDATA,
  input  logic                         PSLVERR
);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  apb_mst_state_e state;
  logic           expired;

  assign req_ready = (state == IDLE);

  apb_timeout_counter #(.CNT_W(CNT_W)) u_tmo (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !PREADY),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      PADDR       <= '0;
      PPROT       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR   <= req_addr;
            PWRITE  <= req_write;
            PPROT   <= req_prot;
            // Reads never drive write data or strobes onto the bus.
            PWDATA  <= req_write ? req_wdata : '0;
            PSTRB   <= req_write ? req_strb  : '0;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (expired) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Transaction-timeline model of the APB requester, checked against the DUT every cycle.
module tb_apb_master_ctrl;
  localparam int AW = 32, DW = 32, SW = 4, T = 16;

  logic PCLK = 1'b0, PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic [2:0]    req_prot = '0;
  logic          rsp_ready = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0;
  logic [DW-1:0] PRDATA = '0;
  logic          req_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE;
  logic [DW-1:0] rsp_rdata, PWDATA;
  logic [AW-1:0] PADDR;
  logic [2:0]    PPROT;
  logic [SW-1:0] PSTRB;

  logic          z_req_valid = 1'b0, z_rsp_ready = 1'b0, z_PREADY = 1'b0;
  logic          z_req_ready, z_rsp_valid, z_rsp_err, z_rsp_timeout, z_PSEL, z_PENABLE, z_PWRITE;
  logic [DW-1:0] z_rsp_rdata, z_PWDATA;
  logic [AW-1:0] z_PADDR;
  logic [2:0]    z_PPROT;
  logic [SW-1:0] z_PSTRB;

  apb_master_ctrl #(.APB_PADDR_WIDTH(AW), .APB_PDATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR));

  apb_master_ctrl #(.APB_PADDR_WIDTH(AW), .APB_PDATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .rsp_timeout(z_rsp_timeout), .PADDR(z_PADDR), .PPROT(z_PPROT), .PSEL(z_PSEL),
    .PENABLE(z_PENABLE), .PWRITE(z_PWRITE), .PWDATA(z_PWDATA), .PSTRB(z_PSTRB), .PREADY(z_PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR));

  int checks = 0, failures = 0;

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b t=%0t", n, act, exp, $time);
    end
  endtask

  // Model: k counts edges since acceptance (1 = SETUP); ACCESS spans L cycles, then response.
  bit busy = 0, m_wr, m_to, m_err;
  int k, L, rcnt, m_w, m_d;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [3:0]  m_s;
  logic [2:0]  m_p;

  bit p_valid = 0, p_wr, p_err, rand_mode = 0, accepted;
  int p_w, p_d;
  logic [31:0] p_addr, p_wd, p_rd;
  logic [3:0]  p_s;
  logic [2:0]  p_p;

  int psel_cnt, pen_cnt, rsp_cycles, rdy_low, rsp_k;
  logic [31:0] o_rd;
  logic o_err, o_to;

  task automatic randomize_p();
    p_valid = ($urandom % 3) != 0;
    p_wr    = 1'($urandom);
    p_addr  = $urandom;
    p_wd    = $urandom;
    p_s     = 4'($urandom);
    p_p     = 3'($urandom);
    p_err   = ($urandom % 4) == 0;
    p_rd    = $urandom;
    p_d     = int'($urandom % 4);
    case ($urandom % 10)
      0: p_w = T - 1;
      1: p_w = T;
      2: p_w = T + 3;
      default: p_w = int'($urandom % 4);
    endcase
  endtask

  task automatic step();
    bit e_psel, e_pen, e_rsp;
    @(negedge PCLK);
    e_rsp  = busy && (k >= 2 + L);
    e_psel = busy && (k >= 1) && (k <= 1 + L);
    e_pen  = busy && (k >= 2) && (k <= 1 + L);
    chk1("req_ready", req_ready, !busy);
    chk1("psel", PSEL, e_psel);
    chk1("penable", PENABLE, e_pen);
    chk1("rsp_valid", rsp_valid, e_rsp);
    if (e_psel) begin
      chk32("paddr", PADDR, m_addr);
      chk1("pwrite", PWRITE, m_wr);
      chk32("pwdata", PWDATA, m_wr ? m_wd : 32'h0);
      chk32("pstrb", 32'(PSTRB), m_wr ? 32'(m_s) : 32'h0);
      chk32("pprot", 32'(PPROT), 32'(m_p));
    end
    if (e_rsp) begin
      chk32("rsp_rdata", rsp_rdata, (m_wr || m_to) ? 32'h0 : m_rd);
      chk1("rsp_err", rsp_err, m_to | m_err);
      chk1("rsp_timeout", rsp_timeout, m_to);
    end
    if (busy) begin
      psel_cnt += int'(PSEL);
      pen_cnt  += int'(PENABLE);
      if (rsp_valid) begin
        rsp_cycles++;
        rdy_low += int'(!req_ready);
        o_rd = rsp_rdata; o_err = rsp_err; o_to = rsp_timeout;
        if (rsp_k < 0) rsp_k = k;
      end
    end
    if (rand_mode) randomize_p();
    req_valid = p_valid; req_write = p_wr; req_addr = p_addr;
    req_wdata = p_wd; req_strb = p_s; req_prot = p_p;
    if (e_pen) begin
      PREADY  = !m_to && (k == 2 + m_w);
      PSLVERR = PREADY ? m_err : 1'($urandom);
      PRDATA  = PREADY ? m_rd : $urandom;
    end else begin
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
    end
    rsp_ready = e_rsp ? (rcnt >= m_d) : 1'($urandom);
    @(posedge PCLK);
    accepted = 0;
    if (!busy) begin
      if (req_valid) begin
        m_wr = p_wr; m_addr = p_addr; m_wd = p_wd; m_s = p_s; m_p = p_p;
        m_w = p_w; m_err = p_err; m_rd = p_rd; m_d = p_d;
        m_to = (T != 0) && (p_w >= T);
        L = m_to ? T : p_w + 1;
        busy = 1; k = 1; rcnt = 0; accepted = 1;
        psel_cnt = 0; pen_cnt = 0; rsp_cycles = 0; rdy_low = 0; rsp_k = -1;
        if (!rand_mode) p_valid = 0;
      end
    end else if (e_rsp && rsp_ready) begin
      busy = 0;
    end else begin
      k++;
      if (e_rsp) rcnt++;
    end
  endtask

  task automatic start_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic [2:0] pr, input int w,
                           input bit e, input logic [31:0] rd, input int d);
    int g = 0;
    p_wr = wr; p_addr = a; p_wd = wd; p_s = s; p_p = pr; p_w = w; p_err = e; p_rd = rd; p_d = d;
    p_valid = 1; accepted = 0;
    while (!accepted && g < 20) begin step(); g++; end
    if (!accepted) chk1("accept_bound", 1'b0, 1'b1);
  endtask

  task automatic finish_txn();
    int g = 0;
    while (busy && g < 300) begin step(); g++; end
    if (busy) chk1("complete_bound", 1'b0, 1'b1);
  endtask

  task automatic pulse_reset(input string n);
    #2 PRESET = 1'b1;
    #1;
    chk1({n, "_psel"}, PSEL, 1'b0);
    chk1({n, "_penable"}, PENABLE, 1'b0);
    chk1({n, "_rsp_valid"}, rsp_valid, 1'b0);
    chk1({n, "_req_ready"}, req_ready, 1'b1);
    busy = 0; p_valid = 0; req_valid = 1'b0;
    @(negedge PCLK);
    #1 PRESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk32("rst_paddr", PADDR, 32'h0);
    chk32("rst_pwdata", PWDATA, 32'h0);
    chk32("rst_pstrb", 32'(PSTRB), 32'h0);
    chk32("rst_pprot", 32'(PPROT), 32'h0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    #1 PRESET = 1'b0;

    start_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 32'h0, 0);
    finish_txn();
    chk32("zw_psel_cycles", 32'(psel_cnt), 32'd2);
    chk32("zw_penable_cycles", 32'(pen_cnt), 32'd1);
    chk32("zw_rsp_latency", 32'(rsp_k), 32'd3);
    chk1("zw_rsp_err", o_err, 1'b0);
    chk32("zw_rsp_rdata", o_rd, 32'h0);

    start_txn(0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3'b011, 3, 0, 32'h1234_5678, 0);
    finish_txn();
    chk32("ws3_access_cycles", 32'(pen_cnt), 32'd4);
    chk32("ws3_rsp_rdata", o_rd, 32'h1234_5678);

    start_txn(0, 32'h0000_0030, 32'h0, 4'h0, 3'b001, 0, 1, 32'h0BAD_0BAD, 3);
    finish_txn();
    chk1("slverr_rsp_err", o_err, 1'b1);
    chk1("slverr_rsp_timeout", o_to, 1'b0);
    chk32("slverr_rsp_cycles", 32'(rsp_cycles), 32'd4);
    chk32("slverr_ready_low", 32'(rdy_low), 32'd4);

    start_txn(0, 32'h0000_0040, 32'h0, 4'h0, 3'b100, 100, 0, 32'hA5A5_A5A5, 1);
    finish_txn();
    chk32("tmo_access_cycles", 32'(pen_cnt), 32'd16);
    chk32("tmo_psel_cycles", 32'(psel_cnt), 32'd17);
    chk1("tmo_rsp_err", o_err, 1'b1);
    chk1("tmo_rsp_timeout", o_to, 1'b1);
    chk32("tmo_rsp_rdata", o_rd, 32'h0);

    start_txn(0, 32'h0000_0050, 32'h0, 4'h0, 3'b000, 15, 0, 32'h0F0F_0F0F, 0);
    finish_txn();
    chk32("ws15_access_cycles", 32'(pen_cnt), 32'd16);
    chk1("ws15_rsp_timeout", o_to, 1'b0);
    chk32("ws15_rsp_rdata", o_rd, 32'h0F0F_0F0F);

    start_txn(1, 32'h0000_0060, 32'h5555_AAAA, 4'h3, 3'b010, 1, 0, 32'h0, 5);
    finish_txn();
    chk32("bp_rsp_cycles", 32'(rsp_cycles), 32'd6);
    chk32("bp_ready_low", 32'(rdy_low), 32'd6);

    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0; p_valid = 0;
    finish_txn();

    start_txn(0, 32'h0000_0080, 32'h0, 4'hF, 3'b101, 100, 0, 32'h55, 0);
    while (busy && k < 6) step();
    pulse_reset("rst_access");
    step(); step();

    start_txn(1, 32'h0000_0090, 32'h1111_2222, 4'hC, 3'b000, 0, 0, 32'h0, 100);
    while (busy && k < 5) step();
    pulse_reset("rst_resp");
    step(); step();

    // Timeout-disabled instance: the transfer must wait as long as PREADY stays low.
    @(negedge PCLK);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0000_0044; req_prot = 3'b010;
    z_req_valid = 1'b1; z_PREADY = 1'b0; z_rsp_ready = 1'b1;
    @(negedge PCLK);
    z_req_valid = 1'b0;
    chk1("t0_setup_psel", z_PSEL, 1'b1);
    chk1("t0_setup_penable", z_PENABLE, 1'b0);
    chk1("t0_req_ready", z_req_ready, 1'b0);
    repeat (40) begin
      @(negedge PCLK);
      chk1("t0_wait_psel", z_PSEL, 1'b1);
      chk1("t0_wait_penable", z_PENABLE, 1'b1);
      chk1("t0_wait_rsp_valid", z_rsp_valid, 1'b0);
    end
    chk32("t0_paddr", z_PADDR, 32'h0000_0044);
    PRDATA = 32'hCAFE_0001; PSLVERR = 1'b0; z_PREADY = 1'b1;
    @(negedge PCLK);
    z_PREADY = 1'b0;
    chk1("t0_rsp_valid", z_rsp_valid, 1'b1);
    chk32("t0_rsp_rdata", z_rsp_rdata, 32'hCAFE_0001);
    chk1("t0_rsp_err", z_rsp_err, 1'b0);
    chk1("t0_rsp_timeout", z_rsp_timeout, 1'b0);
    chk1("t0_resp_psel", z_PSEL, 1'b0);
    @(negedge PCLK);
    chk1("t0_done_rsp_valid", z_rsp_valid, 1'b0);
    chk1("t0_done_req_ready", z_req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
APB4 requester that turns a simple valid/ready request channel into compliant APB SETUP/ACCESS transfers on the APB bus interface signal set. It returns a buffered response (read data and error) on a valid/ready response channel. It sits directly upstream of the APB bus, between system-side initiators (CPU bridge or DMA) and the APB slaves. It supports one outstanding transfer, with a wait-state timeout.

Parameters:
- APB_PADDR_WIDTH, 32, address width of PADDR and req_addr.
- APB_PDATA_WIDTH, 32, data width; must be 8, 16 or 32. PSTRB width is APB_PDATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; single clock domain.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  APB_PADDR_WIDTH  target address.
- req_wdata  in  APB_PDATA_WIDTH  write data.
- req_strb  in  APB_PDATA_WIDTH/8  write byte strobes.
- req_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  APB_PDATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR or timeout.
- rsp_timeout  out  1  qualifies rsp_err as a timeout.
- PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB  out  APB widths  APB requester outputs.
- PREADY, PRDATA, PSLVERR  in  APB widths  APB completer inputs.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Clock port is PCLK; reset port is PRESET.
- Reset values:
  - State is IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0.
  - PADDR, PWDATA, PSTRB, PPROT and rsp_rdata are all-zero.
  - req_ready is 1 (decoded from IDLE).
- Reset mid-transfer: PRESET asserted in any state clears everything immediately, with no clock needed. PSEL drops asynchronously and any pending response is discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except req_ready (= state==IDLE).
- IDLE:
  - On acceptance, register the address, write flag, prot, wdata and strb into the P* outputs.
  - For reads, PSTRB is forced to 0 and PWDATA holds 0.
  - Set PSEL=1 and PENABLE=0, then go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, go to ACCESS, and clear the wait counter.
- ACCESS:
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable for the whole phase.
  - PREADY=1: capture PRDATA into rsp_rdata (reads only; writes give 0) and PSLVERR into rsp_err. Set rsp_timeout=0, drop PSEL and PENABLE, and go to RESP.
  - PREADY=0: increment the wait counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, drop PSEL and PENABLE and set rsp_err=1, rsp_timeout=1 and rsp_rdata=0. Then go to RESP.
  - PSLVERR is sampled only when PREADY=1.
- RESP:
  - rsp_valid=1 and the payload holds until rsp_ready.
  - On handshake, clear rsp_valid and go to IDLE. The next request can be accepted one cycle after the response handshake.
  - rsp_ready may be high before rsp_valid; the handshake still occurs in the first RESP cycle.
- Zero-wait latency: accept at cycle N, SETUP at N+1, ACCESS at N+2 with PREADY=1, rsp_valid at N+3. Minimum issue interval is 4 cycles.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1. It saturates and never wraps.
- No new request is accepted while a response is pending (strictly one outstanding transfer).

Decomposition:
- Package apb_pkg:
  - width defaults;
  - `typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e`;
  - apb_prot_t (3-bit);
  - `localparam` encodings for the PPROT bits.
- Sub-module apb_timeout_counter: clear, enable and limit inputs; expired output. Instantiated once.

Test Plan:
- Zero-wait write (addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF), PREADY tied high → PSEL high for 2 cycles, PENABLE high for cycle 2 only, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states, PRDATA=0x1234_5678 on the PREADY cycle → ACCESS lasts 4 cycles with PADDR stable, PSTRB=0, and rsp_rdata=0x1234_5678.
- Read with PREADY=1 and PSLVERR=1 → rsp_err=1, rsp_timeout=0; next request accepted only after the rsp handshake.
- PREADY stuck low with TIMEOUT_CYCLES=16 → PSEL drops after 16 ACCESS cycles, and rsp_err=1, rsp_timeout=1, rsp_rdata=0. With TIMEOUT_CYCLES=0 the transfer waits indefinitely.
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid and the payload stay stable and req_ready stays 0 throughout.
- PRESET pulsed during ACCESS → PSEL, PENABLE and rsp_valid go to 0 without a clock edge, and req_ready=1 after release.
